// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory-stage load/store unit: MIPS load/store
// opcodes, FSM state encoding, access size and an opcode decoder.
package mem_access_unit_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2b;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef struct packed {
        logic  legal;
        logic  store;
        size_e size;
        logic  sgn;
    } op_info_t;

    function automatic op_info_t decode_op(input logic [5:0] op);
        op_info_t info;
        info.legal = 1'b1;
        info.store = 1'b0;
        info.size  = SZ_WORD;
        info.sgn   = 1'b0;
        case (op)
            OP_LB:   begin info.size = SZ_BYTE; info.sgn = 1'b1; end
            OP_LH:   begin info.size = SZ_HALF; info.sgn = 1'b1; end
            OP_LW:   ;
            OP_LBU:  info.size = SZ_BYTE;
            OP_LHU:  info.size = SZ_HALF;
            OP_SB:   begin info.size = SZ_BYTE; info.store = 1'b1; end
            OP_SH:   begin info.size = SZ_HALF; info.store = 1'b1; end
            OP_SW:   info.store = 1'b1;
            default: info.legal = 1'b0;
        endcase
        return info;
    endfunction

    // Halfwords need an even address, words a multiple of four.
    function automatic logic misaligned(input size_e size, input logic [1:0] off);
        return ((size == SZ_HALF) && off[0]) || ((size == SZ_WORD) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extract.sv
// Load data path: picks the addressed byte or halfword out of a memory word
// and sign- or zero-extends it to 32 bits. Purely combinational.
module load_extract
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  size_e       size_i,
    input  logic        sgn_i,
    output logic [31:0] data_o
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        byteSel = word_i[7:0];
        case (off_i)
            2'd0: byteSel = word_i[7:0];
            2'd1: byteSel = word_i[15:8];
            2'd2: byteSel = word_i[23:16];
            2'd3: byteSel = word_i[31:24];
            default: byteSel = word_i[7:0];
        endcase
        halfSel = off_i[1] ? word_i[31:16] : word_i[15:0];

        data_o = word_i;
        case (size_i)
            SZ_BYTE: data_o = {{24{sgn_i & byteSel[7]}}, byteSel};
            SZ_HALF: data_o = {{16{sgn_i & halfSel[15]}}, halfSel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: narrows stores into byte lanes, extends loads,
// and runs the req/ack handshake to data memory with a timeout.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [5:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        addr_err,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    state_e      state_q, state_d;
    logic [CNT_W-1:0] waitCnt_q, waitCnt_d;
    logic [1:0]  off_q, off_d;
    size_e       size_q, size_d;
    logic        sgn_q, sgn_d;
    logic        memWe_q, memWe_d;
    logic [3:0]  memBe_q, memBe_d;
    logic [31:0] memAddr_q, memAddr_d;
    logic [31:0] memWdata_q, memWdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        addrErr_q, addrErr_d;
    logic        busErr_q, busErr_d;

    op_info_t    reqInfo;
    logic        reqBad;
    logic [3:0]  storeBe;
    logic [31:0] storeData;
    logic [31:0] loadData;

    assign reqInfo = decode_op(req_op);
    assign reqBad  = !reqInfo.legal || misaligned(reqInfo.size, req_addr[1:0]);

    load_extract u_loadExtract (
        .word_i (mem_rdata),
        .off_i  (off_q),
        .size_i (size_q),
        .sgn_i  (sgn_q),
        .data_o (loadData)
    );

    // Store lanes are replicated so the memory only has to honour byte enables.
    always_comb begin
        storeBe   = 4'b1111;
        storeData = req_wdata;
        case (reqInfo.size)
            SZ_BYTE: begin
                storeBe   = 4'b0001 << req_addr[1:0];
                storeData = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
                storeBe   = req_addr[1] ? 4'b1100 : 4'b0011;
                storeData = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
        if (!reqInfo.store) begin
            storeBe   = 4'b1111;
            storeData = 32'd0;
        end
    end

    always_comb begin
        state_d    = state_q;
        waitCnt_d  = waitCnt_q;
        off_d      = off_q;
        size_d     = size_q;
        sgn_d      = sgn_q;
        memWe_d    = memWe_q;
        memBe_d    = memBe_q;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        rdata_d    = rdata_q;
        addrErr_d  = addrErr_q;
        busErr_d   = busErr_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addrErr_d = 1'b0;
                    busErr_d  = 1'b0;
                    if (reqBad) begin
                        addrErr_d = 1'b1;
                        rdata_d   = 32'd0;
                        state_d   = ST_DONE;
                    end else begin
                        off_d      = req_addr[1:0];
                        size_d     = reqInfo.size;
                        sgn_d      = reqInfo.sgn;
                        memWe_d    = reqInfo.store;
                        memBe_d    = storeBe;
                        memAddr_d  = {req_addr[31:2], 2'b00};
                        memWdata_d = storeData;
                        waitCnt_d  = '0;
                        state_d    = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // An ack on the last allowed cycle still counts as success.
                if (mem_ack) begin
                    rdata_d = memWe_q ? 32'd0 : loadData;
                    state_d = ST_DONE;
                end else if (waitCnt_q == CNT_W'(TIMEOUT - 1)) begin
                    busErr_d = 1'b1;
                    rdata_d  = 32'd0;
                    state_d  = ST_DONE;
                end else begin
                    waitCnt_d = waitCnt_q + CNT_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            waitCnt_q  <= '0;
            off_q      <= 2'b00;
            size_q     <= SZ_WORD;
            sgn_q      <= 1'b0;
            memWe_q    <= 1'b0;
            memBe_q    <= 4'b0000;
            memAddr_q  <= 32'd0;
            memWdata_q <= 32'd0;
            rdata_q    <= 32'd0;
            addrErr_q  <= 1'b0;
            busErr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            waitCnt_q  <= waitCnt_d;
            off_q      <= off_d;
            size_q     <= size_d;
            sgn_q      <= sgn_d;
            memWe_q    <= memWe_d;
            memBe_q    <= memBe_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            rdata_q    <= rdata_d;
            addrErr_q  <= addrErr_d;
            busErr_q   <= busErr_d;
        end
    end

    assign stall     = ((state_q == ST_IDLE) && req_valid) || (state_q == ST_WAIT);
    assign mem_req   = (state_q == ST_WAIT);
    assign rsp_valid = (state_q == ST_DONE);
    assign addr_err  = rsp_valid & addrErr_q;
    assign bus_err   = rsp_valid & busErr_q;
    assign rsp_rdata = rdata_q;
    assign mem_we    = memWe_q;
    assign mem_be    = memBe_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a transaction-level model predicts
// every cycle's outputs; directed cases pin known values, then random traffic.
module tb_mem_access_unit;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [5:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        addr_err;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    logic        checkEn = 1'b0;
    logic        expStall, expMemReq, expRspValid, expAddrErr, expBusErr, expWe;
    logic [3:0]  expBe;
    logic [31:0] expAddr, expWdata, expRdata;
    logic [31:0] lastRdata;

    logic [31:0] seenRdata, seenAddr, seenWdata;
    logic [3:0]  seenBe;
    int          reqCycles;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .stall     (stall),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .addr_err  (addr_err),
        .bus_err   (bus_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Single compare point, mid-cycle, against whatever the model expects now.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("stall", {31'd0, stall}, {31'd0, expStall});
            checkOutput("mem_req", {31'd0, mem_req}, {31'd0, expMemReq});
            checkOutput("rsp_valid", {31'd0, rsp_valid}, {31'd0, expRspValid});
            checkOutput("addr_err", {31'd0, addr_err}, {31'd0, expAddrErr});
            checkOutput("bus_err", {31'd0, bus_err}, {31'd0, expBusErr});
            checkOutput("rsp_rdata", rsp_rdata, expRdata);
            if (expMemReq) begin
                checkOutput("mem_we", {31'd0, mem_we}, {31'd0, expWe});
                checkOutput("mem_be", {28'd0, mem_be}, {28'd0, expBe});
                checkOutput("mem_addr", mem_addr, expAddr);
                if (expWe) checkOutput("mem_wdata", mem_wdata, expWdata);
            end
            if (rsp_valid) seenRdata = rsp_rdata;
            if (mem_req) begin
                seenBe    = mem_be;
                seenAddr  = mem_addr;
                seenWdata = mem_wdata;
                reqCycles++;
            end
        end
    end

    // Behavioural model of one access, from opcode semantics and byte arithmetic.
    function automatic void modelTxn(input logic [5:0] op, input logic [31:0] addr,
                                     input logic [31:0] wdata, input logic [31:0] rword,
                                     output bit ok, output bit isStore,
                                     output logic [3:0] be, output logic [31:0] wd,
                                     output logic [31:0] rd);
        int n;
        bit sgn;
        bit known;
        int off;
        logic [31:0] mask;
        logic [31:0] val;
        n = 4; sgn = 0; isStore = 0; known = 1;
        case (op)
            6'h20: begin n = 1; sgn = 1; end
            6'h21: begin n = 2; sgn = 1; end
            6'h23: n = 4;
            6'h24: n = 1;
            6'h25: n = 2;
            6'h28: begin n = 1; isStore = 1; end
            6'h29: begin n = 2; isStore = 1; end
            6'h2b: begin n = 4; isStore = 1; end
            default: known = 0;
        endcase
        off  = int'(addr % 4);
        ok   = known && ((int'(addr % 4) % n) == 0);
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        be   = 4'b1111;
        wd   = 32'd0;
        rd   = 32'd0;
        if (isStore) begin
            be = 4'(((1 << n) - 1) << off);
            if (n == 1) wd = (wdata & 32'hFF) * 32'h0101_0101;
            else if (n == 2) wd = (wdata & 32'hFFFF) * 32'h0001_0001;
            else wd = wdata;
        end else if (ok) begin
            val = (rword >> (8 * off)) & mask;
            if (sgn && val[8 * n - 1]) val = val | ~mask;
            rd = val;
        end
        if (!ok) isStore = 0;
    endfunction

    task automatic setIdle();
        expStall = req_valid; expMemReq = 0; expRspValid = 0;
        expAddrErr = 0; expBusErr = 0; expRdata = lastRdata;
    endtask

    // Drives one access from acceptance through the DONE cycle. ackDelay is the
    // WAIT cycle (0-based) carrying mem_ack, -1 for never; rstAt likewise for reset.
    task automatic applyStimulus(input logic [5:0] op, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int ackDelay,
                                 input logic [31:0] rword, input int rstAt);
        bit ok, isStore, errA, errB;
        logic [3:0] be;
        logic [31:0] wd, rd;
        modelTxn(op, addr, wdata, rword, ok, isStore, be, wd, rd);
        reqCycles = 0;
        errA = !ok; errB = 0;
        req_valid = 1; req_op = op; req_addr = addr; req_wdata = wdata; mem_ack = 0;
        expStall = 1; expMemReq = 0; expRspValid = 0; expAddrErr = 0; expBusErr = 0;
        expRdata = lastRdata;
        expWe = isStore; expBe = be; expAddr = addr & 32'hFFFF_FFFC; expWdata = wd;
        @(posedge clk); #1;
        if (ok) begin
            for (int w = 0; w < TIMEOUT; w++) begin
                expStall = 1; expMemReq = 1; expRspValid = 0;
                mem_ack   = (w == ackDelay);
                mem_rdata = (w == ackDelay) ? rword : $urandom;
                if (rstAt == w) rst = 1;
                @(posedge clk); #1;
                mem_ack = 0;
                if (rstAt == w) begin
                    rst = 0; req_valid = 0; lastRdata = 0;
                    setIdle();
                    mem_ack = 1; mem_rdata = $urandom;
                    @(posedge clk); #1;
                    mem_ack = 0;
                    setIdle();
                    return;
                end
                if (w == ackDelay) break;
                if (w == TIMEOUT - 1) begin
                    errB = 1; rd = 0;
                end
            end
        end
        if (isStore || errA || errB) rd = 0;
        // DONE cycle: a new request and a stray ack here must both be ignored.
        req_valid = 1'($urandom_range(0, 1));
        req_op = 6'($urandom); req_addr = $urandom; req_wdata = $urandom;
        mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
        lastRdata = rd;
        expStall = 0; expMemReq = 0; expRspValid = 1;
        expAddrErr = errA; expBusErr = errB; expRdata = rd;
        @(posedge clk); #1;
        req_valid = 0; mem_ack = 0;
        setIdle();
    endtask

    logic [5:0] opTable [9] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2b, 6'h22};

    initial begin
        rst = 1; req_valid = 0; req_op = 0; req_addr = 0; req_wdata = 0;
        mem_ack = 0; mem_rdata = 0; lastRdata = 0;
        seenRdata = 0; seenBe = 0; seenAddr = 0; seenWdata = 0; reqCycles = 0;
        expWe = 0; expBe = 0; expAddr = 0; expWdata = 0;
        repeat (2) @(posedge clk);
        #1;
        setIdle();
        checkEn = 1;
        @(posedge clk); #1;
        rst = 0;
        setIdle();
        @(posedge clk); #1;

        applyStimulus(6'h28, 32'h0000_1003, 32'h0000_00A5, 0, 32'h0, -1);
        checkOutput("sb_be", {28'd0, seenBe}, 32'h8);
        checkOutput("sb_wdata", seenWdata, 32'hA5A5_A5A5);
        checkOutput("sb_addr", seenAddr, 32'h0000_1000);
        checkOutput("sb_req_cycles", reqCycles, 1);

        applyStimulus(6'h20, 32'h0000_2001, 32'h0, 0, 32'h1234_8056, -1);
        checkOutput("lb_data", seenRdata, 32'hFFFF_FF80);
        applyStimulus(6'h24, 32'h0000_2001, 32'h0, 1, 32'h1234_8056, -1);
        checkOutput("lbu_data", seenRdata, 32'h0000_0080);
        applyStimulus(6'h21, 32'h0000_2002, 32'h0, 2, 32'h1234_8056, -1);
        checkOutput("lh_data", seenRdata, 32'h0000_1234);

        seenRdata = 32'hDEAD_BEEF;
        applyStimulus(6'h23, 32'h0000_3002, 32'h0, 0, 32'h5555_5555, -1);
        checkOutput("lw_misaligned_data", seenRdata, 32'h0);
        checkOutput("lw_misaligned_req", reqCycles, 0);
        applyStimulus(6'h22, 32'h0000_3000, 32'h0, 0, 32'h5555_5555, -1);
        checkOutput("illegal_op_req", reqCycles, 0);

        applyStimulus(6'h23, 32'h0000_4000, 32'h0, 4, 32'hCAFE_F00D, -1);
        checkOutput("lw_delay_req_cycles", reqCycles, 5);
        checkOutput("lw_delay_data", seenRdata, 32'hCAFE_F00D);

        applyStimulus(6'h23, 32'h0000_5000, 32'h0, -1, 32'h0, -1);
        checkOutput("timeout_req_cycles", reqCycles, TIMEOUT);
        applyStimulus(6'h25, 32'h0000_6002, 32'h0, TIMEOUT - 1, 32'h8001_7777, -1);
        checkOutput("late_ack_req_cycles", reqCycles, TIMEOUT);
        checkOutput("late_ack_data", seenRdata, 32'h0000_8001);

        seenRdata = 32'hDEAD_BEEF;
        applyStimulus(6'h2b, 32'h0000_7000, 32'h1111_2222, -1, 32'h0, 3);
        checkOutput("reset_wait_req_cycles", reqCycles, 4);
        checkOutput("reset_no_rsp", seenRdata, 32'hDEAD_BEEF);

        for (int i = 0; i < 150; i++) begin
            logic [5:0] op;
            int pick, delay;
            pick = $urandom_range(0, 9);
            op = (pick == 9) ? 6'($urandom) : opTable[pick];
            case ($urandom_range(0, 7))
                0: delay = -1;
                1: delay = TIMEOUT - 1;
                default: delay = $urandom_range(0, 5);
            endcase
            applyStimulus(op, $urandom, $urandom, delay, $urandom, -1);
        end

        @(posedge clk); #1;
        checkEn = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
